// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory responder: FSM encoding,
// datapath widths and the byte-address to word-index mapping.
package mem_pkg;

  localparam int unsigned MEM_WORD_W = 16;
  localparam int unsigned MEM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [MEM_ADDR_W-2:0] word_index(input logic [MEM_ADDR_W-1:0] addr);
    return addr[MEM_ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 16, registered read. No reset on the
// array or the read register; the top level masks rdata when it is not valid.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem_q [DEPTH];
  logic [MEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a single-outstanding req/ack handshake,
// with a programmable number of wait states between acceptance and ack.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic                  ack,
  output logic [MEM_WORD_W-1:0] rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  acc_we;
  logic [MEM_ADDR_W-1:0] acc_addr;
  logic [MEM_WORD_W-1:0] acc_wdata;
  logic [MEM_ADDR_W-2:0] acc_idx;
  logic                  acc_legal;
  logic                  enter_ack;
  logic [MEM_WORD_W-1:0] ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    enter_ack  = 1'b0;

    // With zero wait states the access happens on the accepting edge, so the
    // live request fields feed the array instead of the latched copies.
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d      = we;
          addr_d    = addr;
          wdata_d   = wdata;
          cnt_d     = 4'(WAIT_STATES);
          acc_we    = we;
          acc_addr  = addr;
          acc_wdata = wdata;
          if (WAIT_STATES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    acc_idx   = word_index(acc_addr);
    acc_legal = !acc_addr[0] && (32'(acc_idx) < DEPTH);

    if (enter_ack) begin
      err_d      = !acc_legal;
      rd_valid_d = acc_legal && !acc_we;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clock(clock),
    .en   (enter_ack && acc_legal),
    .we   (acc_we),
    .idx  (acc_idx[IDX_W-1:0]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  // rdata only reflects the array after a legal read; writes and errors read 0.
  assign rdata = rd_valid_q ? ram_rdata : '0;
  assign ack   = (state_q == ACK);
  assign busy  = (state_q != IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder at 1, 0 and 3 wait states.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];
  logic [15:0] rdata [3];

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_dut_w1 (
    .clock(clock), .reset_n(reset_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut_w0 (
    .clock(clock), .reset_n(reset_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut_w3 (
    .clock(clock), .reset_n(reset_n), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2]));

  typedef struct {
    logic [15:0] rd;
    logic        er;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [3][256];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and push its expected completion from the reference model.
  task automatic start(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd);
    exp_t e;
    int   idx;
    logic legal;
    idx   = int'(a >> 1);
    legal = !a[0] && (idx < 256);
    e.er  = !legal;
    e.rd  = (legal && !w) ? mdl[d][idx] : 16'h0000;
    if (legal && w) mdl[d][idx] = wd;
    sb.push_back(e);
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  // Wait (bounded) for ack, check latency/busy/data, optionally drop req and
  // check the one-cycle ack and held rdata.
  task automatic finish(input int d, input int ws, input int lat, input bit drop);
    int   n = 0;
    exp_t e;
    e.rd = 16'h0000;
    e.er = 1'b0;
    do begin
      @(negedge clock);
      n++;
      if (!ack[d] && n >= lat - ws) check("busy_wait", busy[d], 1);
    end while (!ack[d] && n < 40);
    check("ack_seen", ack[d], 1);
    check("latency", n, lat);
    check("busy_ack", busy[d], 1);
    check("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) e = sb.pop_front();
    check("rdata", rdata[d], e.rd);
    check("err", err[d], e.er);
    if (drop) begin
      req[d] = 1'b0;
      @(negedge clock);
      check("ack_fall", ack[d], 0);
      check("busy_fall", busy[d], 0);
      check("err_fall", err[d], 0);
      check("rdata_hold", rdata[d], e.rd);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) mdl[d][i] = 16'h0000;
      req[d]   = 1'b0;
      we[d]    = 1'b0;
      addr[d]  = 16'h0000;
      wdata[d] = 16'h0000;
    end
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check("rst_ack", ack[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_err", err[d], 0);
      check("rst_rdata", rdata[d], 16'h0000);
    end
    reset_n = 1'b1;
    @(negedge clock);

    // One wait state: basic traffic and error cases
    start(0, 1'b1, 16'h0000, 16'h0005); finish(0, 1, 2, 1);
    start(0, 1'b1, 16'h0004, 16'h0007); finish(0, 1, 2, 1);
    start(0, 1'b0, 16'h0004, 16'h0000); finish(0, 1, 2, 1);
    start(0, 1'b0, 16'h0000, 16'h0000); finish(0, 1, 2, 1);
    start(0, 1'b1, 16'h0002, 16'h0C0C); finish(0, 1, 2, 1);
    start(0, 1'b1, 16'h0003, 16'h1234); finish(0, 1, 2, 1);
    start(0, 1'b0, 16'h0002, 16'h0000); finish(0, 1, 2, 1);
    start(0, 1'b0, 16'h0200, 16'h0000); finish(0, 1, 2, 1);
    start(0, 1'b1, 16'h01FE, 16'h4321); finish(0, 1, 2, 1);
    start(0, 1'b0, 16'h01FE, 16'h0000); finish(0, 1, 2, 1);

    // Zero wait states, including back-to-back requests with req held high
    start(1, 1'b1, 16'h0002, 16'hBEEF); finish(1, 0, 1, 1);
    start(1, 1'b0, 16'h0002, 16'h0000); finish(1, 0, 1, 1);
    start(1, 1'b1, 16'h0006, 16'h1111); finish(1, 0, 1, 0);
    start(1, 1'b0, 16'h0006, 16'h0000); finish(1, 0, 2, 0);
    start(1, 1'b0, 16'h0002, 16'h0000); finish(1, 0, 2, 0);
    start(1, 1'b1, 16'h8000, 16'h2222); finish(1, 0, 2, 1);

    // Three wait states: inputs change during WAIT and must be ignored
    start(2, 1'b1, 16'h0010, 16'hAAAA);
    @(negedge clock);
    addr[2]  = 16'h0020;
    wdata[2] = 16'h5555;
    check("busy_accept", busy[2], 1);
    finish(2, 3, 3, 1);
    start(2, 1'b0, 16'h0010, 16'h0000); finish(2, 3, 4, 1);
    start(2, 1'b0, 16'h0020, 16'h0000); finish(2, 3, 4, 1);

    // Reset in WAIT aborts a write; earlier contents survive
    req[2]   = 1'b1;
    we[2]    = 1'b1;
    addr[2]  = 16'h0008;
    wdata[2] = 16'h00FF;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_busy", busy[2], 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", ack[2], 0);
    check("mid_rst_busy", busy[2], 0);
    check("mid_rst_err", err[2], 0);
    check("mid_rst_rdata", rdata[2], 16'h0000);
    req[2] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("no_ack_after_rst", ack[2], 0);
    end
    start(2, 1'b0, 16'h0008, 16'h0000); finish(2, 3, 4, 1);
    start(2, 1'b0, 16'h0010, 16'h0000); finish(2, 3, 4, 1);
    start(0, 1'b0, 16'h0004, 16'h0000); finish(0, 1, 2, 1);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised 16-bit data memory serving the CPU's `lw`/`sw` accesses over a single-outstanding req/ack handshake. The CPU is the initiator and this block is the responder. It sits beside the instruction memory on the CPU's data side and uses the same byte-address convention: word index = addr >> 1. A programmable number of wait states models slow storage, which exercises the CPU's stall path.

## Interface
Parameters:
- DEPTH, 256, number of 16-bit words; must be a power of two, ≤ 32768.
- WAIT_STATES, 1, extra cycles between request acceptance and ack (0–15).

Ports:
- clock  in  1  single system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid; held high with we/addr/wdata stable until ack is seen.
- we  in  1  1 = write (sw), 0 = read (lw).
- addr  in  16  byte address; word index = addr[15:1].
- wdata  in  16  write data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  16  read data, valid while ack=1.
- err  out  1  error flag, qualified by ack.
- busy  out  1  high from acceptance until the cycle after ack.

## Operation
- States are IDLE, WAIT, ACK.
- IDLE:
  - If req=1 at a rising edge, latch we, addr and wdata, load the wait counter with WAIT_STATES, and assert busy.
  - The next state is WAIT if WAIT_STATES>0, otherwise ACK.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 1, the next edge enters ACK.
  - req, addr, we and wdata are ignored in this state; the latched copies are used.
- Entering ACK (the edge that sets ack=1) does the access:
  - A legal read registers rdata = mem[index].
  - A legal write stores wdata at mem[index] and sets rdata = 0.
- An access is illegal if addr[0]=1 or index ≥ DEPTH:
  - err=1, no write is performed, rdata = 0.
- ACK lasts exactly one cycle, then returns to IDLE.
  - ack, err and busy fall in the next cycle.
  - rdata holds its value until the next ACK.
- A req still high in IDLE after an ack is a new request. The initiator must drop req on the edge where it samples ack=1.
- Memory contents are not cleared by reset. Simulation initial contents are all zero.
- Index arithmetic is unsigned. Upper index bits beyond log2(DEPTH) count as out of range; they never wrap.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE, ack=0, err=0, busy=0, rdata=0x0000, counter=0.
- Latency: if a request is accepted at edge t, ack is high in the cycle following edge t+WAIT_STATES.
  - WAIT_STATES=0: ack is high in the cycle immediately after acceptance.
- Throughput: at most one transaction per WAIT_STATES+2 cycles.
- Reset asserted in WAIT aborts the transaction: no write and no ack. A write that already committed on entry to ACK persists.
- req asserted during WAIT or ACK has no effect until IDLE.
- ack never asserts without a prior accepted req. ack is never high for two consecutive cycles.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - the `MEM_WORD_W`=16 and `MEM_ADDR_W`=16 constants;
  - a `word_index(addr)` helper giving addr[15:1].
- Sub-module `dmem_array` is a single-port synchronous RAM: DEPTH×16, write enable, registered read. The FSM, wait counter, request latch and error check live in the top level.

## Test plan
- Basic read/write, WAIT_STATES=1:
  - Write 0x0005 to addr 0x0000, then write 0x0007 to addr 0x0004.
  - Read addr 0x0004 -> ack 2 cycles after acceptance, rdata=0x0007, err=0.
  - Read addr 0x0000 -> rdata=0x0005.
- Zero wait states (WAIT_STATES=0):
  - Read addr 0x0002 after writing 0xBEEF there -> ack in the cycle after acceptance, rdata=0xBEEF.
  - Issue back-to-back requests -> one transaction every 2 cycles.
- Errors:
  - Write 0x1234 to addr 0x0003 -> ack with err=1, and a subsequent read of 0x0002 returns its old value.
  - Access addr 0x0200 with DEPTH=256 -> ack with err=1, rdata=0x0000.
- Stability:
  - Change addr/wdata from 0x0010/0xAAAA to 0x0020/0x5555 during WAIT (WAIT_STATES=3) -> 0xAAAA is written to 0x0010 and 0x0020 is unchanged.
  - ack width is exactly 1 cycle; busy spans acceptance through ACK.
- Reset mid-operation:
  - Assert reset_n=0 during WAIT of a write of 0x00FF to 0x0008 -> ack/busy/err go 0 immediately; a later read of 0x0008 returns the previous 0x0000.
  - Memory written before the reset is retained.
